rtl_kernel_wizard_0_control_s_axi: RTL

//  AXI4-Lite control slave and register file for the kernel top; upstream of rtl_kernel_wizard_0_example.

---
 rtl/rtl_kernel_wizard_0_control_s_axi.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/rtl_kernel_wizard_0_control_s_axi.sv
// rtl/rtl_kernel_wizard_0_control_s_axi.sv - AXI4-Lite control slave and register file; CTRL_IRQ_EN enables GIE/IER/ISR and interrupt
module rtl_kernel_wizard_0_control_s_axi #(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            ap_clk,
    input  logic                            areset,
    input  logic                            s_axi_control_awvalid,
    output logic                            s_axi_control_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_awaddr,
    input  logic                            s_axi_control_wvalid,
    output logic                            s_axi_control_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_control_wstrb,
    output logic                            s_axi_control_bvalid,
    input  logic                            s_axi_control_bready,
    output logic [1:0]                      s_axi_control_bresp,
    input  logic                            s_axi_control_arvalid,
    output logic                            s_axi_control_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_araddr,
    output logic                            s_axi_control_rvalid,
    input  logic                            s_axi_control_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_rdata,
    output logic [1:0]                      s_axi_control_rresp,
    output logic                            interrupt,
    output logic                            ap_start,
    input  logic                            ap_done,
    input  logic                            ap_idle,
    input  logic                            ap_ready,
    output logic [31:0]                     scalar00,
    output logic [63:0]                     axi00_ptr0
);

    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_GIE    = 6'h04;
    localparam logic [5:0] ADDR_IER    = 6'h08;
    localparam logic [5:0] ADDR_ISR    = 6'h0C;
    localparam logic [5:0] ADDR_SCALAR = 6'h10;
    localparam logic [5:0] ADDR_PTR_LO = 6'h18;
    localparam logic [5:0] ADDR_PTR_HI = 6'h1C;

    typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wr_state_t;
    typedef enum logic {RDIDLE, RDDATA} rd_state_t;

    wr_state_t   wstate;
    rd_state_t   rstate;
    logic [5:0]  waddr;
    logic        rd_ctrl;
    logic        auto_restart;
    logic        int_ap_done;
    logic [31:0] rdata_next;
    logic        w_hs;
    logic        r_hs;
    logic        wr_ctrl;

    // Only the low six address bits are decoded; the rest are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_control_awaddr[C_S_AXI_ADDR_WIDTH-1:6],
                                s_axi_control_araddr[C_S_AXI_ADDR_WIDTH-1:6]};

    assign s_axi_control_bresp = 2'b00;
    assign s_axi_control_rresp = 2'b00;
    assign w_hs    = s_axi_control_wvalid & s_axi_control_wready;
    assign r_hs    = s_axi_control_rvalid & s_axi_control_rready;
    assign wr_ctrl = w_hs && (waddr == ADDR_CTRL) && s_axi_control_wstrb[0];

    function automatic logic [31:0] masked(input logic [31:0] old_val);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++)
            if (s_axi_control_wstrb[b])
                res[b*8 +: 8] = s_axi_control_wdata[b*8 +: 8];
        return res;
    endfunction

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wstate                <= WRIDLE;
            waddr                 <= '0;
            s_axi_control_awready <= 1'b0;
            s_axi_control_wready  <= 1'b0;
            s_axi_control_bvalid  <= 1'b0;
        end else begin
            case (wstate)
                WRIDLE: begin
                    if (s_axi_control_awvalid && s_axi_control_awready) begin
                        waddr                 <= s_axi_control_awaddr[5:0];
                        s_axi_control_awready <= 1'b0;
                        s_axi_control_wready  <= 1'b1;
                        wstate                <= WRDATA;
                    end else begin
                        s_axi_control_awready <= 1'b1;
                    end
                end
                WRDATA: begin
                    if (w_hs) begin
                        s_axi_control_wready <= 1'b0;
                        s_axi_control_bvalid <= 1'b1;
                        wstate               <= WRRESP;
                    end
                end
                WRRESP: begin
                    if (s_axi_control_bvalid && s_axi_control_bready) begin
                        s_axi_control_bvalid  <= 1'b0;
                        s_axi_control_awready <= 1'b1;
                        wstate                <= WRIDLE;
                    end
                end
                default: wstate <= WRIDLE;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            scalar00     <= '0;
            axi00_ptr0   <= '0;
            auto_restart <= 1'b0;
            ap_start     <= 1'b0;
            int_ap_done  <= 1'b0;
        end else begin
            if (w_hs) begin
                case (waddr)
                    ADDR_SCALAR: scalar00          <= masked(scalar00);
                    ADDR_PTR_LO: axi00_ptr0[31:0]  <= masked(axi00_ptr0[31:0]);
                    ADDR_PTR_HI: axi00_ptr0[63:32] <= masked(axi00_ptr0[63:32]);
                    default: ;
                endcase
            end
            if (wr_ctrl)
                auto_restart <= s_axi_control_wdata[7];
            // A host start beats a same-cycle ready so a back-to-back launch is never dropped.
            if (wr_ctrl && s_axi_control_wdata[0])
                ap_start <= 1'b1;
            else if (ap_ready && !auto_restart)
                ap_start <= 1'b0;
            if (ap_done)
                int_ap_done <= 1'b1;
            else if (r_hs && rd_ctrl)
                int_ap_done <= 1'b0;
        end
    end

`ifdef CTRL_IRQ_EN
    logic       gie;
    logic [1:0] ier;
    logic [1:0] isr;
    logic [1:0] irq_event;

    assign irq_event = {ap_ready, ap_done};

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            gie       <= 1'b0;
            ier       <= '0;
            isr       <= '0;
            interrupt <= 1'b0;
        end else begin
            if (w_hs && waddr == ADDR_GIE && s_axi_control_wstrb[0])
                gie <= s_axi_control_wdata[0];
            if (w_hs && waddr == ADDR_IER && s_axi_control_wstrb[0])
                ier <= s_axi_control_wdata[1:0];
            for (int i = 0; i < 2; i++) begin
                if (irq_event[i] && ier[i])
                    isr[i] <= 1'b1;
                else if (w_hs && waddr == ADDR_ISR && s_axi_control_wstrb[0] && s_axi_control_wdata[i])
                    isr[i] <= ~isr[i];
            end
            interrupt <= gie & (|isr);
        end
    end
`else
    assign interrupt = 1'b0;
`endif

    always_comb begin
        rdata_next = '0;
        case (s_axi_control_araddr[5:0])
            ADDR_CTRL:   rdata_next = {24'b0, auto_restart, 3'b0, ap_ready, ap_idle, int_ap_done, ap_start};
`ifdef CTRL_IRQ_EN
            ADDR_GIE:    rdata_next = {31'b0, gie};
            ADDR_IER:    rdata_next = {30'b0, ier};
            ADDR_ISR:    rdata_next = {30'b0, isr};
`endif
            ADDR_SCALAR: rdata_next = scalar00;
            ADDR_PTR_LO: rdata_next = axi00_ptr0[31:0];
            ADDR_PTR_HI: rdata_next = axi00_ptr0[63:32];
            default:     rdata_next = '0;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            rstate                <= RDIDLE;
            rd_ctrl               <= 1'b0;
            s_axi_control_arready <= 1'b0;
            s_axi_control_rvalid  <= 1'b0;
            s_axi_control_rdata   <= '0;
        end else begin
            case (rstate)
                RDIDLE: begin
                    if (s_axi_control_arvalid && s_axi_control_arready) begin
                        s_axi_control_arready <= 1'b0;
                        s_axi_control_rvalid  <= 1'b1;
                        s_axi_control_rdata   <= rdata_next;
                        rd_ctrl               <= (s_axi_control_araddr[5:0] == ADDR_CTRL);
                        rstate                <= RDDATA;
                    end else begin
                        s_axi_control_arready <= 1'b1;
                    end
                end
                RDDATA: begin
                    if (s_axi_control_rready) begin
                        s_axi_control_rvalid  <= 1'b0;
                        s_axi_control_arready <= 1'b1;
                        rstate                <= RDIDLE;
                    end
                end
                default: rstate <= RDIDLE;
            endcase
        end
    end

endmodule
